ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one port of the dual-port 32k x 32 RAM wrapper between two requesters of the RISC-V core: instruction fetch (IF, read-only) and load/store data (D, read/write).
- Owns that port's request handshake: latches the winning request, drives it into the wrapper, and holds it stable through the wrapper's multi-cycle sequence.
- Returns read data or write completion to the winning requester.
- One instance per core; the other RAM port is free for debug/DMA.

Parameters:
ADDR_W, 15, word address width (32k words)
DATA_W, 32, data width; byte enables are DATA_W/8 bits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req  in  1  IF read request; held until if_ack
if_addr  in  ADDR_W  IF word address
if_ack  out  1  IF request accepted (one cycle)
if_rvalid  out  1  IF read data valid (one-cycle pulse)
if_rdata  out  DATA_W  IF read data
d_req  in  1  data request; held until d_ack
d_we  in  4  byte write enables; 0 = read
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  write data
d_ack  out  1  data request accepted (one cycle)
d_done  out  1  data access complete (one-cycle pulse)
d_rdata  out  DATA_W  data read result, valid with d_done on reads
ram_req  out  1  request strobe to RAM wrapper (one cycle)
ram_we  out  4  byte enables to wrapper
ram_addr  out  ADDR_W  address to wrapper
ram_din  out  DATA_W  write data to wrapper
ram_dout  in  DATA_W  wrapper read data
ram_request_done  in  1  wrapper idle flag (registered, level)
ram_read_valid  in  1  wrapper read-valid pulse
busy  out  1  transaction in flight (state != IDLE)
owner  out  1  0 = IF, 1 = D; owner of current or last transaction

Behaviour:
- Single clock domain; reset is synchronous, active-high. Reset values: state IDLE; all ack/valid/done/ram_req outputs 0; ram_we 0; ram_addr, ram_din, if_rdata, d_rdata 0; owner 0 (IF); busy 0.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Grant condition: (if_req | d_req) & ram_request_done.
  - On grant, ack the winner combinationally in the same cycle (if_ack or d_ack) and latch addr/we/wdata into ram_* registers. IF grants force ram_we = 0.
  - Update owner and go to ISSUE.
  - A requester whose req is low gets no ack.
- ISSUE: ram_req = 1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for ram_request_done == 0, then go to WAIT_DONE.
- WAIT_DONE:
  - Completion when ram_read_valid == 1 (read) or ram_request_done == 1 (write).
  - On completion, register ram_dout into if_rdata or d_rdata (reads only), pulse if_rvalid or d_done the next cycle, and go to IDLE.
- ram_addr, ram_we and ram_din stay stable from the grant edge until return to IDLE. ram_we returns to 0 on entry to IDLE.
- Latency: grant cycle T -> rvalid/done at T+5 for both reads and writes against the wrapper. Back-to-back throughput is one access per 5 cycles; a new grant is legal in the same cycle as the previous rvalid/done.
- Tie (both req in IDLE): data wins (default arbitration).
- Requests arriving while busy are not acked; they must stay asserted.
- Write data/enables are 4 byte lanes; no width conversion.
- Reset mid-transaction: the arbiter returns to IDLE; no completion pulse is issued for the aborted access. The wrapper has no reset and finishes its sequence. The ram_request_done gate blocks the next grant until the wrapper is idle.
- busy = (state != IDLE).

Optional Feature:
- RAM_ARB_RR_EN defined: round-robin on ties.
  - On simultaneous requests, grant the requester not granted last (tracked by owner).
  - Reset owner = IF, so the first tie goes to D.
  - Single requests are granted regardless of owner.
- RAM_ARB_RR_EN undefined: fixed priority, D always wins ties. IF may starve under continuous D traffic; the core pipeline makes this acceptable.

Decomposition:
- Package ram_arb_pkg:
  - state enum (IDLE/ISSUE/WAIT_BUSY/WAIT_DONE)
  - owner constants OWN_IF = 0, OWN_D = 1
  - RAM_LAT = 5 (grant-to-completion cycles, for the bench)
  - default ADDR_W/DATA_W
- Sub-module ram_arb_pick: combinational grant selection from if_req, d_req, owner and ram_request_done; outputs grant_if and grant_d. Compiles RR or fixed priority under RAM_ARB_RR_EN.
- FSM, latches and return path stay in ram_port_arbiter.

Test Plan:
- IF-only read: if_req with if_addr = 0x0010, RAM word 0x0010 = 0xDEADBEEF -> if_ack at T, ram_req at T+1 with ram_we = 0, if_rvalid at T+5 with if_rdata = 0xDEADBEEF; no d_done.
- D byte write then read: d_we = 4'b0010, d_addr = 0x7FFF, d_wdata = 0x0000AB00, then a read of 0x7FFF over a prior 0x11223344 -> d_done twice; read returns 0x1122AB44. ram_we is 0 in IDLE between the two.
- Simultaneous requests, both held for 4 transactions:
  - Fixed priority: grant order D, D, D, D; if_ack never asserts.
  - RAM_ARB_RR_EN: grant order D, IF, D, IF.
- Request while busy: d_req asserted at T+2 during an IF read -> no d_ack until T+5; d_ack asserts at T+5 alongside if_rvalid.
- Reset mid-transaction: rst at T+2 of a read -> all outputs at reset values at T+3; no if_rvalid. New if_req at T+3 -> no ack until ram_request_done is high again, then a normal 5-cycle read returns correct data.
- Wrapper idle gate: force ram_request_done = 0 with if_req high -> no if_ack and busy = 0; release -> if_ack the same cycle.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter (IF/D sharing one RAM wrapper port).
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   // Grant cycle to rvalid/done cycle against the wrapper.
   localparam int RAM_LAT = 5;

   localparam int DEF_ADDR_W = 15;
   localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant selection for the RAM port arbiter.
// RAM_ARB_RR_EN selects round-robin tie-breaking; otherwise data always wins ties.
module ram_arb_pick
   import ram_arb_pkg::*;
(
   input  logic if_req,
   input  logic d_req,
`ifdef RAM_ARB_RR_EN
   input  logic owner,
`endif
   input  logic ram_request_done,
   output logic grant_if,
   output logic grant_d
);

   // Pick a winner only while the wrapper reports idle.
   always_comb begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
      if (ram_request_done) begin
`ifdef RAM_ARB_RR_EN
         if (if_req && d_req) begin
            grant_d  = (owner == OWN_IF);
            grant_if = (owner == OWN_D);
         end else begin
            grant_d  = d_req;
            grant_if = if_req;
         end
`else
         grant_d  = d_req;
         grant_if = if_req & ~d_req;
`endif
      end else begin
         grant_if = 1'b0;
         grant_d  = 1'b0;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM wrapper port between instruction fetch (read-only) and load/store data.
// Define RAM_ARB_RR_EN for round-robin tie-breaking instead of data-first priority.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_ack,
   output logic                  if_rvalid,
   output logic [DATA_W-1:0]     if_rdata,
   input  logic                  d_req,
   input  logic [DATA_W/8-1:0]   d_we,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   output logic                  d_ack,
   output logic                  d_done,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  ram_req,
   output logic [DATA_W/8-1:0]   ram_we,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_din,
   input  logic [DATA_W-1:0]     ram_dout,
   input  logic                  ram_request_done,
   input  logic                  ram_read_valid,
   output logic                  busy,
   output logic                  owner
);

   arb_state_t state;
   logic       grant_if;
   logic       grant_d;
   logic       ram_is_read;
   logic       complete;

   ram_arb_pick u_pick (
      .if_req           (if_req),
      .d_req            (d_req),
`ifdef RAM_ARB_RR_EN
      .owner            (owner),
`endif
      .ram_request_done (ram_request_done),
      .grant_if         (grant_if),
      .grant_d          (grant_d)
   );

   assign busy        = (state != IDLE);
   assign ram_is_read = (ram_we == '0);

   // Acks are combinational so the requester can drop req right after the grant cycle.
   always_comb begin
      if_ack   = 1'b0;
      d_ack    = 1'b0;
      complete = 1'b0;
      if (state == IDLE) begin
         if_ack = grant_if;
         d_ack  = grant_d;
      end else begin
         if_ack = 1'b0;
         d_ack  = 1'b0;
      end
      if (ram_is_read) begin
         complete = ram_read_valid;
      end else begin
         complete = ram_request_done;
      end
   end

   // Transaction FSM with latched request fields and registered return path.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ram_req   <= 1'b0;
         ram_we    <= '0;
         ram_addr  <= '0;
         ram_din   <= '0;
         if_rvalid <= 1'b0;
         if_rdata  <= '0;
         d_done    <= 1'b0;
         d_rdata   <= '0;
         owner     <= OWN_IF;
      end else begin
         ram_req   <= 1'b0;
         if_rvalid <= 1'b0;
         d_done    <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  ram_we   <= d_we;
                  ram_addr <= d_addr;
                  ram_din  <= d_wdata;
                  owner    <= OWN_D;
                  ram_req  <= 1'b1;
                  state    <= ISSUE;
               end else if (grant_if) begin
                  ram_we   <= '0;
                  ram_addr <= if_addr;
                  ram_din  <= '0;
                  owner    <= OWN_IF;
                  ram_req  <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               // The wrapper's idle flag is registered; wait until it has seen the strobe.
               if (!ram_request_done) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (complete) begin
                  state  <= IDLE;
                  ram_we <= '0;
                  if (owner == OWN_IF) begin
                     if_rvalid <= 1'b1;
                     if_rdata  <= ram_dout;
                  end else begin
                     d_done <= 1'b1;
                     if (ram_is_read) begin
                        d_rdata <= ram_dout;
                     end
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural RAM wrapper model.
module tb_ram_port_arbiter;
   import ram_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [14:0] if_addr = 15'h0;
   logic        if_ack, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic [3:0]  d_we = 4'h0;
   logic [14:0] d_addr = 15'h0;
   logic [31:0] d_wdata = 32'h0;
   logic        d_ack, d_done;
   logic [31:0] d_rdata;
   logic        ram_req;
   logic [3:0]  ram_we;
   logic [14:0] ram_addr;
   logic [31:0] ram_din;
   logic [31:0] ram_dout = 32'h0;
   logic        ram_request_done;
   logic        ram_read_valid = 1'b0;
   logic        busy, owner;

   logic        hold_busy = 1'b0;
   logic        wr_idle = 1'b1;
   logic [1:0]  wr_cnt = 2'd0;
   logic [3:0]  wr_we = 4'h0;
   logic [14:0] wr_addr = 15'h0;
   logic [31:0] wr_din = 32'h0;
   logic [31:0] mem [0:32767];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_port_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_done(d_done), .d_rdata(d_rdata),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout), .ram_request_done(ram_request_done), .ram_read_valid(ram_read_valid),
      .busy(busy), .owner(owner)
   );

   // Wrapper: idle drops the cycle after the strobe, two busy cycles, then idle + read_valid.
   assign ram_request_done = wr_idle & ~hold_busy;

   always @(posedge clk) begin
      ram_read_valid <= 1'b0;
      if (wr_idle) begin
         if (ram_req) begin
            wr_idle <= 1'b0;
            wr_cnt  <= 2'd2;
            wr_we   <= ram_we;
            wr_addr <= ram_addr;
            wr_din  <= ram_din;
         end
      end else begin
         wr_cnt <= wr_cnt - 2'd1;
         if (wr_cnt == 2'd1) begin
            wr_idle <= 1'b1;
            if (wr_we == 4'h0) begin
               ram_read_valid <= 1'b1;
               ram_dout       <= mem[wr_addr];
            end else begin
               for (int b = 0; b < 4; b++)
                  if (wr_we[b]) mem[wr_addr][8*b +: 8] = wr_din[8*b +: 8];
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      n_cmp++;
      if ({busy, ram_req, ram_we, if_rvalid, d_done, owner, if_ack, d_ack} !== 10'h0) begin
         n_err++;
         $display("FAIL reset_ctl: got %b want 0", {busy, ram_req, ram_we, if_rvalid, d_done, owner, if_ack, d_ack});
      end
      n_cmp++;
      if ({ram_addr, ram_din, if_rdata, d_rdata} !== 111'h0) begin
         n_err++;
         $display("FAIL reset_data: addr=%h din=%h ir=%h dr=%h want 0", ram_addr, ram_din, if_rdata, d_rdata);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_if_read();
      int got = 0;
      int extra_req = 0;
      int dd = 0;
      tick();
      if_req = 1'b1;
      if_addr = 15'h0010;
      @(negedge clk);
      n_cmp++;
      if (if_ack !== 1'b1 || d_ack !== 1'b0) begin
         n_err++;
         $display("FAIL ifr_ack: if_ack=%b d_ack=%b want 1 0", if_ack, d_ack);
      end
      tick();
      if_req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({ram_req, ram_we, ram_addr} !== {1'b1, 4'h0, 15'h0010}) begin
         n_err++;
         $display("FAIL ifr_issue: req=%b we=%h addr=%h want 1 0 0010", ram_req, ram_we, ram_addr);
      end
      for (int c = 2; c <= 6; c++) begin
         tick();
         @(negedge clk);
         if (if_rvalid && got == 0) got = c;
         if (ram_req) extra_req++;
         if (d_done) dd++;
      end
      n_cmp++;
      if (got != RAM_LAT) begin
         n_err++;
         $display("FAIL ifr_latency: got %0d want %0d", got, RAM_LAT);
      end
      n_cmp++;
      if (if_rdata !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL ifr_data: got %h want deadbeef", if_rdata);
      end
      n_cmp++;
      if (extra_req != 0 || dd != 0) begin
         n_err++;
         $display("FAIL ifr_pulses: extra ram_req=%0d d_done=%0d want 0 0", extra_req, dd);
      end
   endtask

   task automatic test_d_write_read();
      int got = 0;
      logic [3:0] we_mid = 4'h0;
      logic [3:0] we_done = 4'hF;
      tick();
      d_req = 1'b1;
      d_we = 4'b0010;
      d_addr = 15'h7FFF;
      d_wdata = 32'h0000AB00;
      @(negedge clk);
      n_cmp++;
      if (d_ack !== 1'b1 || if_ack !== 1'b0) begin
         n_err++;
         $display("FAIL dw_ack: d_ack=%b if_ack=%b want 1 0", d_ack, if_ack);
      end
      tick();
      d_req = 1'b0;
      d_we = 4'h0;
      d_wdata = 32'h0;
      @(negedge clk);
      n_cmp++;
      if ({ram_req, ram_we, ram_addr, ram_din} !== {1'b1, 4'b0010, 15'h7FFF, 32'h0000AB00}) begin
         n_err++;
         $display("FAIL dw_issue: req=%b we=%b addr=%h din=%h", ram_req, ram_we, ram_addr, ram_din);
      end
      for (int c = 2; c <= 6; c++) begin
         tick();
         @(negedge clk);
         if (c == 4) we_mid = ram_we;
         if (d_done && got == 0) begin
            got = c;
            we_done = ram_we;
         end
      end
      n_cmp++;
      if (got != RAM_LAT || we_mid !== 4'b0010 || we_done !== 4'h0) begin
         n_err++;
         $display("FAIL dw_done: cycle=%0d we_mid=%b we_idle=%b want 5 0010 0000", got, we_mid, we_done);
      end
      tick();
      d_req = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (d_ack !== 1'b1) begin
         n_err++;
         $display("FAIL dr_ack: got %b want 1", d_ack);
      end
      got = 0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         d_req = 1'b0;
         @(negedge clk);
         if (d_done && got == 0) got = c;
      end
      n_cmp++;
      if (got != RAM_LAT || d_rdata !== 32'h1122AB44) begin
         n_err++;
         $display("FAIL dr_data: cycle=%0d data=%h want 5 1122ab44", got, d_rdata);
      end
   endtask

   task automatic test_tie();
      int k = 0;
      int last = 0;
      int cyc = 0;
      logic exp_w;
      logic got_w;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      if_req = 1'b1;
      d_req = 1'b1;
      d_we = 4'h0;
      if_addr = 15'h0010;
      d_addr = 15'h7FFF;
      while (k < 4 && cyc < 40) begin
         @(negedge clk);
         if (if_ack || d_ack) begin
`ifdef RAM_ARB_RR_EN
            exp_w = (k % 2 == 0) ? OWN_D : OWN_IF;
`else
            exp_w = OWN_D;
`endif
            got_w = d_ack ? OWN_D : OWN_IF;
            n_cmp++;
            if ((if_ack & d_ack) || got_w !== exp_w) begin
               n_err++;
               $display("FAIL tie_order[%0d]: if_ack=%b d_ack=%b want owner %b", k, if_ack, d_ack, exp_w);
            end
            if (k > 0) begin
               n_cmp++;
               if (cyc - last != RAM_LAT) begin
                  n_err++;
                  $display("FAIL tie_spacing[%0d]: got %0d want %0d", k, cyc - last, RAM_LAT);
               end
            end
            last = cyc;
            k++;
         end
         tick();
         cyc++;
      end
      if_req = 1'b0;
      d_req = 1'b0;
      n_cmp++;
      if (k != 4) begin
         n_err++;
         $display("FAIL tie_timeout: got %0d grants want 4", k);
      end
      repeat (6) tick();
   endtask

   task automatic test_busy_req();
      int got = 0;
      int early = 0;
      tick();
      if_req = 1'b1;
      if_addr = 15'h0010;
      @(negedge clk);
      n_cmp++;
      if (if_ack !== 1'b1) begin
         n_err++;
         $display("FAIL busy_ifack: got %b want 1", if_ack);
      end
      tick();
      if_req = 1'b0;
      tick();
      d_req = 1'b1;
      d_we = 4'h0;
      d_addr = 15'h7FFF;
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         if (d_ack) early++;
         tick();
      end
      @(negedge clk);
      n_cmp++;
      if (early != 0) begin
         n_err++;
         $display("FAIL busy_noack: got %0d early acks want 0", early);
      end
      n_cmp++;
      if (d_ack !== 1'b1 || if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL busy_handover: d_ack=%b if_rvalid=%b if_rdata=%h want 1 1 deadbeef", d_ack, if_rvalid, if_rdata);
      end
      for (int c = 1; c <= 6; c++) begin
         tick();
         d_req = 1'b0;
         @(negedge clk);
         if (d_done && got == 0) got = c;
      end
      n_cmp++;
      if (got != RAM_LAT || d_rdata !== 32'h1122AB44) begin
         n_err++;
         $display("FAIL busy_dread: cycle=%0d data=%h want 5 1122ab44", got, d_rdata);
      end
   endtask

   task automatic test_reset_mid();
      int got = 0;
      int dd = 0;
      tick();
      d_req = 1'b1;
      d_we = 4'h0;
      d_addr = 15'h7FFF;
      @(negedge clk);
      n_cmp++;
      if (d_ack !== 1'b1) begin
         n_err++;
         $display("FAIL rmid_ack: got %b want 1", d_ack);
      end
      tick();
      d_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      if_req = 1'b1;
      if_addr = 15'h0020;
      @(negedge clk);
      n_cmp++;
      if ({busy, ram_req, ram_we, ram_addr, ram_din, if_rvalid, d_done, owner} !== 55'h0 ||
          if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL rmid_state: busy=%b req=%b we=%h addr=%h own=%b ir=%h dr=%h want 0",
                  busy, ram_req, ram_we, ram_addr, owner, if_rdata, d_rdata);
      end
      n_cmp++;
      if (if_ack !== 1'b0) begin
         n_err++;
         $display("FAIL rmid_gate: if_ack=%b want 0 while wrapper busy", if_ack);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (if_ack !== 1'b1) begin
         n_err++;
         $display("FAIL rmid_regrant: if_ack=%b want 1", if_ack);
      end
      for (int c = 1; c <= 6; c++) begin
         tick();
         if_req = 1'b0;
         @(negedge clk);
         if (if_rvalid && got == 0) got = c;
         if (d_done) dd++;
      end
      n_cmp++;
      if (got != RAM_LAT || if_rdata !== 32'hCAFEF00D || dd != 0) begin
         n_err++;
         $display("FAIL rmid_read: cycle=%0d data=%h d_done=%0d want 5 cafef00d 0", got, if_rdata, dd);
      end
   endtask

   task automatic test_idle_gate();
      int bad = 0;
      int got = 0;
      tick();
      hold_busy = 1'b1;
      if_req = 1'b1;
      if_addr = 15'h0020;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (if_ack !== 1'b0 || busy !== 1'b0) bad++;
         tick();
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL gate_hold: %0d cycles with ack or busy, want 0", bad);
      end
      hold_busy = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (if_ack !== 1'b1) begin
         n_err++;
         $display("FAIL gate_release: if_ack=%b want 1", if_ack);
      end
      for (int c = 1; c <= 6; c++) begin
         tick();
         if_req = 1'b0;
         @(negedge clk);
         if (if_rvalid && got == 0) got = c;
      end
      n_cmp++;
      if (got != RAM_LAT || if_rdata !== 32'hCAFEF00D) begin
         n_err++;
         $display("FAIL gate_read: cycle=%0d data=%h want 5 cafef00d", got, if_rdata);
      end
   endtask

   initial begin
      mem[15'h0010] = 32'hDEADBEEF;
      mem[15'h0020] = 32'hCAFEF00D;
      mem[15'h7FFF] = 32'h11223344;
      test_reset();
      test_if_read();
      test_d_write_read();
      test_tie();
      test_busy_req();
      test_reset_mid();
      test_idle_gate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
